// File: rtl/rf_pkg.sv
// Shared register-file writeback types: address/data widths and the queued
// writeback entry used by the arbiter, reg_file and the hazard unit.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wr;
    logic [DATA_W-1:0]     wd;
    logic                  live;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_A,
    GRANT_B
  } grant_t;

  // True when a write to wr would actually land on register addr (r0 is never written).
  function automatic logic targets(input logic [REG_ADDR_W-1:0] wr,
                                   input logic [REG_ADDR_W-1:0] addr);
    return (wr == addr) && (wr != REG_ZERO);
  endfunction

endpackage

// File: rtl/rf_wb_queue.sv
// FIFO of pending long-latency writebacks. Each entry carries a live bit that
// a younger in-order write to the same register can clear (WAW kill); the
// pend outputs tell the hazard unit which snooped read addresses are still
// waiting on a queued write.
module rf_wb_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enq,
  input  logic [REG_ADDR_W-1:0]   enq_wr,
  input  logic [DATA_W-1:0]       enq_wd,
  input  logic                    deq,
  input  logic                    kill,
  input  logic [REG_ADDR_W-1:0]   kill_wr,
  input  logic [REG_ADDR_W-1:0]   pr1,
  input  logic [REG_ADDR_W-1:0]   pr2,
  output wb_entry_t               head,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    pend1,
  output logic                    pend2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic [REG_ADDR_W-1:0] wr_mem [DEPTH];
  logic [DATA_W-1:0]     wd_mem [DEPTH];
  logic [DEPTH-1:0]      live_q;

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry payload storage.
  // NOTE: payload arrays have no reset; an entry is only meaningful while its live bit is set.
  always_ff @(posedge clk) begin
    if (enq) begin
      wr_mem[wr_ptr] <= enq_wr;
      wd_mem[wr_ptr] <= enq_wd;
    end
  end

  // Live bits: killed by a matching in-order write, cleared on dequeue, set on enqueue.
  // The enqueue assignment comes last so a same-cycle younger entry survives the kill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && (wr_mem[i] == kill_wr)) live_q[i] <= 1'b0;
      end
      if (deq) live_q[rd_ptr] <= 1'b0;
      if (enq) live_q[wr_ptr] <= 1'b1;
    end
  end

  assign head  = '{wr: wr_mem[rd_ptr], wd: wd_mem[rd_ptr], live: live_q[rd_ptr]};
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

  // Match trees: any live queued entry that will write a snooped read address.
  // NOTE: outputs get a default before the loop so no latch is inferred.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && targets(wr_mem[i], pr1)) pend1 = 1'b1;
      if (live_q[i] && targets(wr_mem[i], pr2)) pend2 = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the in-order writeback (A) and
// a queued long-latency return path (B). A has priority until B's head has
// been passed over STARVE_LIMIT times in a row, then B gets one forced slot.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [REG_ADDR_W-1:0]   a_wr,
  input  logic [DATA_W-1:0]       a_wd,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [REG_ADDR_W-1:0]   b_wr,
  input  logic [DATA_W-1:0]       b_wd,
  input  logic [REG_ADDR_W-1:0]   PR1,
  input  logic [REG_ADDR_W-1:0]   PR2,
  output logic                    pend1,
  output logic                    pend2,
  output logic                    rf_write,
  output logic [REG_ADDR_W-1:0]   rf_wr,
  output logic [DATA_W-1:0]       rf_wd,
  output logic [$clog2(DEPTH):0]  q_count
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic      [SC_W-1:0] starve_cnt;
  logic                 q_empty;
  logic                 q_full;
  logic                 forced;
  logic                 enq;
  logic                 kill;
  wb_entry_t            head;
  grant_t               grant;

  assign forced  = !q_empty && (starve_cnt == STARVE_MAX);
  assign a_ready = !forced;
  assign b_ready = !q_full;
  assign enq     = b_valid && b_ready;
  assign kill    = (grant == GRANT_A) && (a_wr != REG_ZERO);

  // At most one grant per cycle: A when it is ready, otherwise the queue head.
  always_comb begin
    grant = GRANT_NONE;
    if (a_valid && a_ready) grant = GRANT_A;
    else if (!q_empty)      grant = GRANT_B;
  end

  rf_wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .reset   (reset),
    .enq     (enq),
    .enq_wr  (b_wr),
    .enq_wd  (b_wd),
    .deq     (grant == GRANT_B),
    .kill    (kill),
    .kill_wr (a_wr),
    .pr1     (PR1),
    .pr2     (PR2),
    .head    (head),
    .empty   (q_empty),
    .full    (q_full),
    .count   (q_count),
    .pend1   (pend1),
    .pend2   (pend2)
  );

  // Starvation counter: counts A wins over a waiting head, saturating; any dequeue or empty queue clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if ((grant == GRANT_A) && !q_empty) begin
      if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Write-port register: the granted item drives reg_file next cycle unless it targets r0 or was killed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_write <= 1'b0;
      rf_wr    <= '0;
      rf_wd    <= '0;
    end else begin
      case (grant)
        GRANT_A: begin
          rf_write <= (a_wr != REG_ZERO);
          rf_wr    <= a_wr;
          rf_wd    <= a_wd;
        end
        GRANT_B: begin
          rf_write <= head.live && (head.wr != REG_ZERO);
          rf_wr    <= head.wr;
          rf_wd    <= head.wd;
        end
        default: rf_write <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a queue-based reference model predicts
// handshakes, pend flags, occupancy and the exact cycle of every reg_file
// write; a separate monitor matches the DUT's writes against that schedule.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        a_valid, a_ready;
  logic [4:0]  a_wr;
  logic [31:0] a_wd;
  logic        b_valid, b_ready;
  logic [4:0]  b_wr;
  logic [31:0] b_wd;
  logic [4:0]  pr1, pr2;
  logic        pend1, pend2;
  logic        rf_write;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic [2:0]  q_count;

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_wr     (a_wr),
    .a_wd     (a_wd),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_wr     (b_wr),
    .b_wd     (b_wd),
    .PR1      (pr1),
    .PR2      (pr2),
    .pend1    (pend1),
    .pend2    (pend2),
    .rf_write (rf_write),
    .rf_wr    (rf_wr),
    .rf_wd    (rf_wd),
    .q_count  (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int          cyc;
    logic [4:0]  wr;
    logic [31:0] wd;
  } exp_t;

  typedef struct {
    logic [4:0]  wr;
    logic [31:0] wd;
    bit          live;
  } ment_t;

  exp_t  sb[$];
  ment_t mq[$];
  int    starve = 0;
  int    total  = 0;
  int    bad    = 0;

  bit          b_hold = 0;
  logic [4:0]  hold_wr;
  logic [31:0] hold_wd;
  bit          mon_on = 0;
  logic        obs_a_ready;
  logic [31:0] tb_rf [32];
  int          r5_writes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model for one cycle: checks combinational outputs, then applies the cycle's grant/enqueue.
  task automatic model_cycle();
    bit  empty, grant_a, exp_a_ready, exp_b_ready, ep1, ep2;
    ment_t h;
    empty       = (mq.size() == 0);
    exp_a_ready = !(!empty && starve == STARVE_LIMIT);
    exp_b_ready = (mq.size() < DEPTH);
    ep1 = 0;
    ep2 = 0;
    foreach (mq[i]) begin
      if (mq[i].live && mq[i].wr != 0 && mq[i].wr == pr1) ep1 = 1;
      if (mq[i].live && mq[i].wr != 0 && mq[i].wr == pr2) ep2 = 1;
    end
    obs_a_ready = a_ready;
    check("a_ready", a_ready, exp_a_ready);
    check("b_ready", b_ready, exp_b_ready);
    check("pend1",   pend1,   ep1);
    check("pend2",   pend2,   ep2);
    check("q_count", q_count, mq.size());

    grant_a = a_valid && exp_a_ready;
    if (grant_a) begin
      if (a_wr != 0) begin
        sb.push_back('{cyc + 1, a_wr, a_wd});
        foreach (mq[i]) if (mq[i].wr == a_wr) mq[i].live = 0;
      end
      starve = empty ? 0 : ((starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT);
    end else if (!empty) begin
      h = mq.pop_front();
      if (h.live && h.wr != 0) sb.push_back('{cyc + 1, h.wr, h.wd});
      starve = 0;
    end else begin
      starve = 0;
    end
    if (b_valid && exp_b_ready) mq.push_back('{b_wr, b_wd, 1'b1});
    b_hold  = b_valid && !exp_b_ready;
    hold_wr = b_wr;
    hold_wd = b_wd;
  endtask

  // One clock cycle of stimulus; a B request refused last cycle is re-presented unchanged.
  task automatic step(input bit av, input logic [4:0] awr, input logic [31:0] awd,
                      input bit bv, input logic [4:0] bwr, input logic [31:0] bwd,
                      input logic [4:0] p1, input logic [4:0] p2);
    @(posedge clk);
    #1;
    if (b_hold) begin
      bv  = 1;
      bwr = hold_wr;
      bwd = hold_wd;
    end
    a_valid = av;  a_wr = awr;  a_wd = awd;
    b_valid = bv;  b_wr = bwr;  b_wd = bwd;
    pr1 = p1;      pr2 = p2;
    @(negedge clk);
    model_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Mid-cycle reset: state and any in-flight write must vanish immediately.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    reset   = 1'b1;
    a_valid = 0;
    b_valid = 0;
    #1;
    check("rst_q_count",  q_count,  0);
    check("rst_rf_write", rf_write, 0);
    check("rst_pend1",    pend1,    0);
    check("rst_a_ready",  a_ready,  1);
    check("rst_b_ready",  b_ready,  1);
    sb.delete();
    mq.delete();
    starve = 0;
    b_hold = 0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: every DUT write must be the next scheduled one, in the scheduled cycle.
  always @(negedge clk) begin
    if (mon_on && !reset) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_write: got none expected r%0d=%0h at cycle %0d", sb[0].wr, sb[0].wd, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (rf_write) begin
        tb_rf[rf_wr] = rf_wd;
        if (rf_wr == 5) r5_writes++;
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got r%0d=%0h expected no write (cycle %0d)", rf_wr, rf_wd, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rf_wr", rf_wr, e.wr);
          check("rf_wd", rf_wd, e.wd);
        end
      end
    end
  end

  initial begin
    int lows;
    reset = 1'b1;
    a_valid = 0; a_wr = 0; a_wd = 0;
    b_valid = 0; b_wr = 0; b_wd = 0;
    pr1 = 0; pr2 = 0;
    foreach (tb_rf[i]) tb_rf[i] = 32'hdead_beef;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("reset_rf_write", rf_write, 0);
    check("reset_rf_wr",    rf_wr,    0);
    check("reset_rf_wd",    rf_wd,    0);
    check("reset_q_count",  q_count,  0);
    check("reset_a_ready",  a_ready,  1);
    check("reset_b_ready",  b_ready,  1);
    check("reset_pend",     {pend1, pend2}, 0);
    mon_on = 1;

    // A writes r4=31, then reg_file holds 31 for r4.
    step(1, 4, 31, 0, 0, 0, 4, 0);
    idle(2);
    check("r4_value", tb_rf[4], 31);

    // B enqueues r10 and r12 with A idle; PR1 snoops r10.
    step(0, 0, 0, 1, 10, 10, 10, 12);
    step(0, 0, 0, 1, 12, 12, 10, 12);
    idle(3);

    // A streams while r7 waits: exactly one forced cycle.
    lows = 0;
    step(1, 1, 100, 1, 7, 77, 7, 0);
    if (!obs_a_ready) lows++;
    for (int i = 0; i < 7; i++) begin
      step(1, 5'(2 + i), 32'(200 + i), 0, 0, 0, 7, 0);
      if (!obs_a_ready) lows++;
    end
    check("forced_cycles", lows, 1);
    idle(2);

    // WAW kill: queued r5=1 is overtaken by A r5=2.
    r5_writes = 0;
    step(0, 0, 0, 1, 5, 1, 5, 0);
    step(1, 5, 2, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    idle(2);
    check("r5_value",  tb_rf[5], 2);
    check("r5_writes", r5_writes, 1);

    // Fill to DEPTH behind r0 writes from A, including a B write to r0; fifth request must wait and wrap.
    step(1, 0, 9, 1, 1, 11, 1, 3);
    step(1, 0, 9, 1, 2, 22, 2, 3);
    step(1, 0, 9, 1, 0, 33, 0, 3);
    step(1, 0, 9, 1, 3, 44, 3, 9);
    step(1, 0, 9, 1, 9, 99, 1, 9);
    step(1, 0, 9, 1, 9, 99, 2, 9);
    step(0, 0, 0, 0, 0, 0, 9, 3);
    idle(6);

    // Reset with three queued entries and an A write in flight.
    step(1, 0, 0, 1, 11, 1, 11, 12);
    step(1, 0, 0, 1, 12, 2, 11, 12);
    step(1, 13, 3, 1, 14, 4, 11, 14);
    mid_reset();
    idle(4);

    // Randomized traffic with a small register range to provoke kills and pend hits.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (i == 200) mid_reset();
    end
    idle(12);
    check("scoreboard_drained", sb.size(), 0);
    mon_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
